limits_buffer_arbiter: RTL and testbench
========================================

Name: limits_buffer_arbiter

Overview:
- Round-robin arbiter that shares port 2 of the 256x32 dual-port limits buffer between two on-chip requesters.
  - Requester 0: the reconstruction engine, which reads limits.
  - Requester 1: the limits loader / DMA, which writes and reads back.
- Port 1 of the buffer stays with the HPS bridge and is not touched by this block.
- Each requester sees an Avalon-MM-style slave with waitrequest and readdatavalid. The block drives the RAM port and tracks read-latency tags.

Parameters:
- ADDR_W, 8, word address width (256 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- READ_LATENCY, 1, RAM cycles from accepted read to valid readdata (address registered, output unregistered); legal values 1..3.
- RR_ENABLE, 1, 1 = round-robin, 0 = fixed priority with m0 highest.

Ports:
- clk  in  1  single clock, shared with the buffer's clk2.
- reset  in  1  synchronous, active-high.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_byteenable  in  BE_W  write byte lanes.
- m0_writedata  in  DATA_W  write data.
- m0_waitrequest  out  1  1 = command not accepted this cycle.
- m0_readdata  out  DATA_W  read data.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_address, m1_read, m1_write, m1_byteenable, m1_writedata, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0, for requester 1.
- ram_address  out  ADDR_W  to buffer address2.
- ram_chipselect  out  1  to chipselect2.
- ram_write  out  1  to write2.
- ram_byteenable  out  BE_W  to byteenable2.
- ram_writedata  out  DATA_W  to writedata2.
- ram_readdata  in  DATA_W  from readdata2.

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, on port reset.
- Request definitions: req_n = mN_read | mN_write. A grant is computed combinationally each cycle from req_n and the last_grant register.
- Arbitration:
  - Only one request asserted: that requester wins.
  - Both asserted, RR_ENABLE=1: the requester not equal to last_grant wins.
  - Both asserted, RR_ENABLE=0: m0 always wins.
- Acceptance and waitrequest:
  - mN_waitrequest = req_n & ~grant_n, or reset.
  - Idle requesters see waitrequest 0.
  - Accepted command = req & ~waitrequest in the same cycle. Zero-cycle acceptance; no added command latency.
- RAM command:
  - ram_* is a combinational mux of the granted requester's signals.
  - ram_chipselect = any grant.
  - ram_byteenable is forced to all-ones for reads.
  - With no grant: ram_chipselect=0 and ram_write=0; the other ram_* outputs hold the m0 values (don't care).
- last_grant: updates on every accepted command. Reset value is 1, so m0 wins the first contention.
- Read tag pipeline:
  - READ_LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads {accepted_read, granted_id} every cycle.
  - At the pipeline output: mN_readdatavalid = valid & (id==N).
  - mN_readdata = ram_readdata, broadcast to both ports; it is only meaningful when readdatavalid is high.
- Throughput: back-to-back accepted reads are legal, one per cycle. With READ_LATENCY=1, a read accepted in cycle t gives readdatavalid in cycle t+1 with the word at the address sampled in t.
- Read and write asserted together by one requester: treated as a write. No readdatavalid is produced.
- Writes produce no response. A write accepted in cycle t is visible to a read accepted in t+1.
- Reset:
  - Tag pipeline cleared; all readdatavalid = 0.
  - Both waitrequests = 1; ram_chipselect = 0 and ram_write = 0.
  - Reads in flight when reset is asserted are dropped: no readdatavalid follows, even after reset deasserts.
- Coherency with the HPS port: same-address accesses from the HPS port are not arbitrated here. The buffer's mixed-port read-during-write is DONT_CARE; software partitions addresses.
- Interface rule: requesters must hold their command stable while waitrequest=1. A violation is a bench assertion, not handled in RTL.

Decomposition:
- Shared package limits_buf_pkg:
  - LB_ADDR_W=8, LB_DATA_W=32, LB_BE_W=4, LB_READ_LATENCY=1.
  - Typedef lb_req_t {address, read, write, byteenable, writedata}.
  - Typedef lb_tag_t {valid, id}.
- One natural sub-module: lb_rd_tag_pipe, the parameterised-depth tag shift register with synchronous clear.

Test Plan:
- Single m0 read of addr 0x10 (preloaded 0xDEADBEEF), m1 idle -> m0_waitrequest=0 in the request cycle; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Both request continuously from reset, RR_ENABLE=1 (m0 reads 0x00.., m1 reads 0x80..) -> grants alternate m0,m1,m0,m1; each requester has waitrequest=1 on alternate cycles; readdatavalid tags match the requester every cycle.
- Same contention with RR_ENABLE=0 -> m0 granted every cycle; m1_waitrequest held at 1 until m0 drops its request, then m1 is accepted the same cycle.
- m1 writes 0x12345678 with byteenable 0b0011 to addr 0x05 (prior 0xAAAAAAAA); m0 reads 0x05 the next cycle -> m0_readdata=0xAAAA5678.
- m0 read accepted at cycle t, reset high at t+1 -> no readdatavalid at t+1 or later; both waitrequests=1 during reset; first contention after reset is granted to m0.
- m0 asserts read and write together at addr 0x20 with data 0x1 -> word written; m0_readdatavalid never asserts for that command.

Source files
------------

// File: rtl/limits_buf_pkg.sv
// Shared types and defaults for the limits-buffer port-2 arbiter.
package limits_buf_pkg;

  localparam int LB_ADDR_W       = 8;
  localparam int LB_DATA_W       = 32;
  localparam int LB_BE_W         = 4;
  localparam int LB_READ_LATENCY = 1;

  // Requester identity; also the encoding of last_grant and read tags.
  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } lb_port_e;

  typedef struct packed {
    logic [LB_ADDR_W-1:0] address;
    logic                 read;
    logic                 write;
    logic [LB_BE_W-1:0]   byteenable;
    logic [LB_DATA_W-1:0] writedata;
  } lb_req_t;

  typedef struct packed {
    logic     valid;
    lb_port_e id;
  } lb_tag_t;

endpackage

// File: rtl/lb_rd_tag_pipe.sv
// Read-latency tag shift register: tracks which requester owns each
// in-flight RAM read. Synchronous clear drops everything in flight.
module lb_rd_tag_pipe
  import limits_buf_pkg::*;
#(
  parameter int unsigned DEPTH = LB_READ_LATENCY
) (
  input  logic    clk,
  input  logic    reset,
  input  lb_tag_t in_tag,
  output lb_tag_t out_tag
);

  lb_tag_t stage [DEPTH];

  // Shift tags one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/limits_buffer_arbiter.sv
// Shares port 2 of the 256x32 limits buffer between the reconstruction
// engine (m0) and the limits loader/DMA (m1). Zero-cycle acceptance,
// round-robin or fixed-priority, with read-response routing by tag.
module limits_buffer_arbiter
  import limits_buf_pkg::*;
#(
  parameter int ADDR_W       = LB_ADDR_W,
  parameter int DATA_W       = LB_DATA_W,
  parameter int BE_W         = LB_BE_W,
  parameter int READ_LATENCY = LB_READ_LATENCY,
  parameter int RR_ENABLE    = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic     req0, req1;
  logic     grant0, grant1, any_grant;
  logic     sel_read, sel_write;
  logic     accepted_read;
  lb_port_e last_grant;
  lb_port_e grant_id;
  lb_tag_t  tag_in, tag_out;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (RR_ENABLE != 0 && last_grant == GRANT_M0) grant1 = 1'b1;
        else                                           grant0 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign any_grant = grant0 | grant1;
  assign grant_id  = grant1 ? GRANT_M1 : GRANT_M0;

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  // RAM command mux; a combined read+write is issued as a write.
  always_comb begin
    sel_read       = grant1 ? m1_read       : m0_read;
    sel_write      = grant1 ? m1_write      : m0_write;
    ram_address    = grant1 ? m1_address    : m0_address;
    ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
    ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    if (!sel_write) ram_byteenable = '1;
    ram_chipselect = any_grant;
    ram_write      = any_grant & sel_write;
    accepted_read  = any_grant & sel_read & ~sel_write;
  end

  // Remember the last accepted requester for round-robin fairness.
  always_ff @(posedge clk) begin
    if (reset)          last_grant <= GRANT_M1;
    else if (any_grant) last_grant <= grant_id;
  end

  assign tag_in = '{valid: accepted_read, id: grant_id};

  lb_rd_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .in_tag (tag_in),
    .out_tag(tag_out)
  );

  // Gating with reset masks a tag that was loaded on the edge reset rose.
  assign m0_readdatavalid = ~reset & tag_out.valid & (tag_out.id == GRANT_M0);
  assign m1_readdatavalid = ~reset & tag_out.valid & (tag_out.id == GRANT_M1);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_limits_buffer_arbiter.sv
// Scoreboard bench for limits_buffer_arbiter: a round-robin instance and a
// fixed-priority instance, each on its own behavioural 256x32 RAM.
module tb_limits_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [7:0]  m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [7:0]  ram_address;
  logic        ram_chipselect, ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;

  logic        f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
  logic [31:0] f_m0_readdata, f_m1_readdata;
  logic [7:0]  f_ram_address;
  logic        f_ram_chipselect, f_ram_write;
  logic [3:0]  f_ram_byteenable;
  logic [31:0] f_ram_writedata, f_ram_readdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q0[$], q1[$], fq0[$], fq1[$];
  bit mon_rr = 1'b1;
  bit mon_fp = 1'b0;

  always #5 clk = ~clk;

  limits_buffer_arbiter #(
    .READ_LATENCY(1),
    .RR_ENABLE   (1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  limits_buffer_arbiter #(
    .READ_LATENCY(1),
    .RR_ENABLE   (0)
  ) u_fix (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
    .m0_readdatavalid(f_m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
    .m1_readdatavalid(f_m1_readdatavalid),
    .ram_address(f_ram_address), .ram_chipselect(f_ram_chipselect),
    .ram_write(f_ram_write), .ram_byteenable(f_ram_byteenable),
    .ram_writedata(f_ram_writedata), .ram_readdata(f_ram_readdata)
  );

  // Preload image: every word is C0DE00aa except two hand-picked words.
  function automatic logic [31:0] init_word(input int i);
    logic [7:0] a;
    a = i[7:0];
    if (a == 8'h10)      return 32'hDEADBEEF;
    else if (a == 8'h05) return 32'hAAAAAAAA;
    else                 return 32'hC0DE0000 | {24'h0, a};
  endfunction

  // Behavioural RAMs: registered address, unregistered read data.
  logic [31:0] mem   [256];
  logic [31:0] mem_f [256];
  logic [7:0]  addr_q = '0, addr_fq = '0;
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]   <= init_word(i);
        mem_f[i] <= init_word(i);
      end
      loaded <= 1'b1;
    end else begin
      if (ram_chipselect) begin
        if (ram_write)
          for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        addr_q <= ram_address;
      end
      if (f_ram_chipselect) begin
        if (f_ram_write)
          for (int b = 0; b < 4; b++)
            if (f_ram_byteenable[b]) mem_f[f_ram_address][8*b +: 8] <= f_ram_writedata[8*b +: 8];
        addr_fq <= f_ram_address;
      end
    end
  end

  assign ram_readdata   = mem[addr_q];
  assign f_ram_readdata = mem_f[addr_fq];

  // Requesters must hold a stalled command stable.
  a_m0_hold: assert property (@(posedge clk) disable iff (reset)
    ((m0_read | m0_write) && m0_waitrequest) |=>
      $stable({m0_address, m0_read, m0_write, m0_byteenable, m0_writedata}))
    else $error("m0 changed its command while stalled");
  a_m1_hold: assert property (@(posedge clk) disable iff (reset)
    ((m1_read | m1_write) && m1_waitrequest) |=>
      $stable({m1_address, m1_read, m1_write, m1_byteenable, m1_writedata}))
    else $error("m1 changed its command while stalled");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  // Response monitor: pops the oldest expected word on each readdatavalid.
  always @(negedge clk) begin
    if (mon_rr) begin
      if (m0_readdatavalid) begin
        if (q0.size() == 0) chk("m0 spurious readdatavalid", 32'd1, 32'd0);
        else                chk("m0 readdata", m0_readdata, q0.pop_front());
      end
      if (m1_readdatavalid) begin
        if (q1.size() == 0) chk("m1 spurious readdatavalid", 32'd1, 32'd0);
        else                chk("m1 readdata", m1_readdata, q1.pop_front());
      end
    end
    if (mon_fp) begin
      if (f_m0_readdatavalid) begin
        if (fq0.size() == 0) chk("fp m0 spurious readdatavalid", 32'd1, 32'd0);
        else                 chk("fp m0 readdata", f_m0_readdata, fq0.pop_front());
      end
      if (f_m1_readdatavalid) begin
        if (fq1.size() == 0) chk("fp m1 spurious readdatavalid", 32'd1, 32'd0);
        else                 chk("fp m1 readdata", f_m1_readdata, fq1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a0, a1;
    // Reset with both requesters already asking.
    m0_read = 1'b1; m0_address = 8'h00;
    m1_read = 1'b1; m1_address = 8'h80;
    next();
    repeat (2) begin
      @(negedge clk);
      chk("reset m0_waitrequest", m0_waitrequest, 1);
      chk("reset m1_waitrequest", m1_waitrequest, 1);
      chk("reset ram_chipselect", ram_chipselect, 0);
      chk("reset ram_write", ram_write, 0);
      chk("reset m0_readdatavalid", m0_readdatavalid, 0);
      chk("reset m1_readdatavalid", m1_readdatavalid, 0);
      next();
    end

    // Round-robin contention: m0 first, then alternating.
    reset = 1'b0;
    a0 = 8'h00; a1 = 8'h80;
    for (int k = 0; k < 8; k++) begin
      m0_address = a0; m1_address = a1;
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rr m0_waitrequest", m0_waitrequest, 0);
        chk("rr m1_waitrequest", m1_waitrequest, 1);
        chk("rr ram_address", ram_address, a0);
        q0.push_back(32'hC0DE0000 | {24'h0, a0});
        a0 = a0 + 8'd1;
      end else begin
        chk("rr m0_waitrequest", m0_waitrequest, 1);
        chk("rr m1_waitrequest", m1_waitrequest, 0);
        chk("rr ram_address", ram_address, a1);
        q1.push_back(32'hC0DE0000 | {24'h0, a1});
        a1 = a1 + 8'd1;
      end
      next();
    end
    m1_read = 1'b0;
    @(negedge clk);
    chk("rr tail m0_waitrequest", m0_waitrequest, 0);
    q0.push_back(32'hC0DE0004);
    next();
    idle();
    next(); next();

    // Single m0 read of the preloaded word at 0x10.
    m0_read = 1'b1; m0_address = 8'h10;
    @(negedge clk);
    chk("single m0_waitrequest", m0_waitrequest, 0);
    chk("single m1_waitrequest", m1_waitrequest, 0);
    chk("single ram_byteenable", ram_byteenable, 4'hF);
    q0.push_back(32'hDEADBEEF);
    next();
    idle();
    @(negedge clk);
    chk("single m0_readdatavalid", m0_readdatavalid, 1);
    chk("single m1_readdatavalid", m1_readdatavalid, 0);
    next(); next();

    // Partial write by m1, read back by m0 on the following cycle.
    m1_write = 1'b1; m1_address = 8'h05; m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
    @(negedge clk);
    chk("wr m1_waitrequest", m1_waitrequest, 0);
    chk("wr ram_write", ram_write, 1);
    chk("wr ram_byteenable", ram_byteenable, 4'b0011);
    next();
    idle();
    m0_read = 1'b1; m0_address = 8'h05;
    @(negedge clk);
    chk("rb m0_waitrequest", m0_waitrequest, 0);
    chk("rb ram_write", ram_write, 0);
    q0.push_back(32'hAAAA5678);
    next();
    idle();
    next(); next();

    // Read and write together: a write with no response.
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 8'h20;
    m0_writedata = 32'h00000001; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("rw m0_waitrequest", m0_waitrequest, 0);
    chk("rw ram_write", ram_write, 1);
    next();
    idle();
    @(negedge clk);
    chk("rw m0_readdatavalid", m0_readdatavalid, 0);
    next();
    m0_read = 1'b1; m0_address = 8'h20;
    @(negedge clk);
    q0.push_back(32'h00000001);
    next();
    idle();
    next(); next();

    // Read in flight when reset rises is dropped.
    m0_read = 1'b1; m0_address = 8'h03;
    @(negedge clk);
    chk("abort m0_waitrequest", m0_waitrequest, 0);
    next();
    reset = 1'b1;
    m0_read = 1'b1; m0_address = 8'h40;
    m1_read = 1'b1; m1_address = 8'hC0;
    repeat (2) begin
      @(negedge clk);
      chk("abort m0_readdatavalid", m0_readdatavalid, 0);
      chk("abort m0_waitrequest", m0_waitrequest, 1);
      chk("abort m1_waitrequest", m1_waitrequest, 1);
      chk("abort ram_chipselect", ram_chipselect, 0);
      next();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset m0_waitrequest", m0_waitrequest, 0);
    chk("post-reset m1_waitrequest", m1_waitrequest, 1);
    q0.push_back(32'hC0DE0040);
    next();
    m0_read = 1'b0;
    @(negedge clk);
    chk("post-reset m1 accept", m1_waitrequest, 0);
    q1.push_back(32'hC0DE00C0);
    next();
    idle();
    next(); next(); next();

    // Fixed-priority instance under the same contention.
    mon_rr = 1'b0;
    mon_fp = 1'b1;
    m0_read = 1'b1; m0_address = 8'h01;
    m1_read = 1'b1; m1_address = 8'h81;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fp m0_waitrequest", f_m0_waitrequest, 0);
      chk("fp m1_waitrequest", f_m1_waitrequest, 1);
      fq0.push_back(32'hC0DE0001);
      next();
    end
    m0_read = 1'b0;
    @(negedge clk);
    chk("fp m1 accept", f_m1_waitrequest, 0);
    chk("fp m0 idle waitrequest", f_m0_waitrequest, 0);
    fq1.push_back(32'hC0DE0081);
    next();
    idle();
    next(); next();

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("fq0 drained", fq0.size(), 0);
    chk("fq1 drained", fq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
